// File: rtl/mem_stage_lsu_if.sv
// MEM-stage LSU bundle: EX/MEM operands, external stall, data-memory port and writeback result.
// The master modport is the LSU's view; slave is the pipeline/memory side.
interface mem_stage_lsu_if;
   logic [4:0]  m_op_i;
   logic [2:0]  m_f3_i;
   logic [31:0] m_addr_i;
   logic [31:0] m_wdata_i;
   logic        ext_stall_i;
   logic        dm_req_o;
   logic        dm_we_o;
   logic [31:0] dm_addr_o;
   logic [3:0]  dm_wstrb_o;
   logic [31:0] dm_wdata_o;
   logic        dm_ready_i;
   logic        dm_rvalid_i;
   logic [31:0] dm_rdata_i;
   logic [31:0] m_result_o;
   logic        stall_o;
   logic        misalign_o;
   logic        bus_err_o;

   modport master (
      input  m_op_i, m_f3_i, m_addr_i, m_wdata_i, ext_stall_i,
      input  dm_ready_i, dm_rvalid_i, dm_rdata_i,
      output dm_req_o, dm_we_o, dm_addr_o, dm_wstrb_o, dm_wdata_o,
      output m_result_o, stall_o, misalign_o, bus_err_o
   );

   modport slave (
      output m_op_i, m_f3_i, m_addr_i, m_wdata_i, ext_stall_i,
      output dm_ready_i, dm_rvalid_i, dm_rdata_i,
      input  dm_req_o, dm_we_o, dm_addr_o, dm_wstrb_o, dm_wdata_o,
      input  m_result_o, stall_o, misalign_o, bus_err_o
   );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues data-memory accesses, formats load data, stalls until done.
// Request is combinational on issue; an access that completes under ext stall parks in HOLD so it is never reissued.
module mem_stage_lsu #(
   parameter int TIMEOUT_CYC = 64,
   parameter int CNT_W       = 8
) (
   input logic             clk,
   input logic             rst,
   mem_stage_lsu_if.master bus
);
   typedef enum logic [1:0] {IDLE, REQ, RESP, HOLD} state_t;

   state_t           state, nxt;
   logic [CNT_W-1:0] cnt, cnt_cur;
   logic [31:0]      hold_q;
   logic             hold_sel;

   logic        is_load, is_store, is_mem, misal, tmo_hit;
   logic [1:0]  a_lo;
   logic [31:0] rd_sh, ld_fmt, st_data, result;
   logic [15:0] rd_h;
   logic [3:0]  st_strb;
   logic        req, done, err, stall, mis;

   assign is_load  = (bus.m_op_i == 5'b00000);
   assign is_store = (bus.m_op_i == 5'b01000);
   assign is_mem   = is_load | is_store;
   assign a_lo     = bus.m_addr_i[1:0];
   assign misal    = ((bus.m_f3_i[1:0] == 2'b01) && a_lo[0]) ||
                     ((bus.m_f3_i[1:0] == 2'b10) && (a_lo != 2'b00));

   assign rd_sh = bus.dm_rdata_i >> {a_lo, 3'b000};
   assign rd_h  = a_lo[1] ? bus.dm_rdata_i[31:16] : bus.dm_rdata_i[15:0];

   always_comb begin
      case (bus.m_f3_i)
         3'b000:  ld_fmt = {{24{rd_sh[7]}}, rd_sh[7:0]};
         3'b001:  ld_fmt = {{16{rd_h[15]}}, rd_h};
         3'b100:  ld_fmt = {24'd0, rd_sh[7:0]};
         3'b101:  ld_fmt = {16'd0, rd_h};
         default: ld_fmt = bus.dm_rdata_i;
      endcase
   end

   always_comb begin
      case (bus.m_f3_i[1:0])
         2'b00: begin
            st_strb = 4'b0001 << a_lo;
            st_data = {4{bus.m_wdata_i[7:0]}};
         end
         2'b01: begin
            st_strb = 4'b0011 << a_lo;
            st_data = {2{bus.m_wdata_i[15:0]}};
         end
         default: begin
            st_strb = 4'b1111;
            st_data = bus.m_wdata_i;
         end
      endcase
   end

   // The issue cycle counts as cycle 1 even though the register is still clear in IDLE.
   assign cnt_cur = (state == IDLE) ? CNT_W'(1) : cnt;
   assign tmo_hit = (TIMEOUT_CYC != 0) && (cnt_cur >= CNT_W'(TIMEOUT_CYC));

   always_comb begin
      nxt    = state;
      req    = 1'b0;
      done   = 1'b0;
      err    = 1'b0;
      stall  = 1'b0;
      mis    = 1'b0;
      result = bus.m_addr_i;
      if (!rst) begin
         case (state)
            IDLE: begin
               if (is_mem && misal) begin
                  mis    = 1'b1;
                  result = 32'd0;
               end else if (is_mem) begin
                  req = 1'b1;
                  if (bus.dm_ready_i) begin
                     if (is_store) done = 1'b1;
                     else begin
                        nxt   = RESP;
                        stall = 1'b1;
                     end
                  end else if (tmo_hit) err = 1'b1;
                  else begin
                     nxt   = REQ;
                     stall = 1'b1;
                  end
               end
            end
            REQ: begin
               req = 1'b1;
               if (bus.dm_ready_i) begin
                  if (is_store) done = 1'b1;
                  else begin
                     nxt   = RESP;
                     stall = 1'b1;
                  end
               end else if (tmo_hit) err = 1'b1;
               else stall = 1'b1;
            end
            RESP: begin
               if (bus.dm_rvalid_i) begin
                  done   = 1'b1;
                  result = ld_fmt;
               end else if (tmo_hit) err = 1'b1;
               else stall = 1'b1;
            end
            HOLD: begin
               result = hold_sel ? hold_q : bus.m_addr_i;
               if (!bus.ext_stall_i) nxt = IDLE;
            end
            default: nxt = IDLE;
         endcase
         if (err) begin
            req    = 1'b0;
            result = 32'd0;
         end
         if (done || err) nxt = bus.ext_stall_i ? HOLD : IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         hold_q   <= 32'd0;
         hold_sel <= 1'b0;
      end else begin
         state <= nxt;
         if (done || err) begin
            cnt      <= '0;
            hold_q   <= err ? 32'd0 : ld_fmt;
            hold_sel <= err | is_load;
         end else if (nxt == REQ || nxt == RESP) begin
            cnt <= (cnt_cur == '1) ? cnt_cur : cnt_cur + CNT_W'(1);
         end else begin
            cnt <= '0;
         end
      end
   end

   assign bus.dm_req_o   = req;
   assign bus.dm_we_o    = req & is_store;
   assign bus.dm_addr_o  = {bus.m_addr_i[31:2], 2'b00};
   assign bus.dm_wstrb_o = (req & is_store) ? st_strb : 4'b0000;
   assign bus.dm_wdata_o = st_data;
   assign bus.m_result_o = result;
   assign bus.stall_o    = stall;
   assign bus.misalign_o = mis;
   assign bus.bus_err_o  = err;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: per-op expectations go into a scoreboard when driven and are checked at completion.
module tb_mem_stage_lsu;
   localparam logic [4:0] OP_LOAD  = 5'b00000;
   localparam logic [4:0] OP_STORE = 5'b01000;
   localparam logic [4:0] OP_ALU   = 5'b01100;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_stage_lsu_if bus();
   mem_stage_lsu #(.TIMEOUT_CYC(4), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      string       tag;
      logic [31:0] result;
      logic        mis;
      logic        err;
      int          n_acc;
      int          n_stall;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.m_op_i      = OP_ALU;
      bus.m_f3_i      = 3'b000;
      bus.m_addr_i    = 32'd0;
      bus.m_wdata_i   = 32'd0;
      bus.ext_stall_i = 1'b0;
      bus.dm_ready_i  = 1'b0;
      bus.dm_rvalid_i = 1'b0;
      bus.dm_rdata_i  = 32'd0;
   endtask

   // Memory model: ready from cycle rdy_dly onward (-1 = never); rvalid once, rv_lat after accept (0 = never).
   task automatic run_op(input string tag, input logic [4:0] op, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                         input int rdy_dly, input int rv_lat, input int ext_from, input int ext_len,
                         input logic [31:0] e_res, input logic e_mis, input logic e_err,
                         input int e_acc, input int e_stall, input logic [3:0] e_strb,
                         input logic [31:0] e_wdata);
      exp_t        e;
      logic [31:0] res  = 32'd0;
      logic        mis  = 1'b0;
      logic        err  = 1'b0;
      int          acc  = 0;
      int          stl  = 0;
      logic [3:0]  strb = 4'd0;
      logic [31:0] wd   = 32'd0;
      bit          fin  = 1'b0;

      e.tag = tag; e.result = e_res; e.mis = e_mis; e.err = e_err;
      e.n_acc = e_acc; e.n_stall = e_stall; e.wstrb = e_strb; e.wdata = e_wdata;
      sb.push_back(e);

      bus.m_op_i     = op;
      bus.m_f3_i     = f3;
      bus.m_addr_i   = addr;
      bus.m_wdata_i  = wdata;
      bus.dm_rdata_i = rdata;
      for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
         bus.dm_ready_i  = (rdy_dly >= 0) && (cyc >= rdy_dly);
         bus.dm_rvalid_i = (rv_lat > 0) && (rdy_dly >= 0) && (cyc == rdy_dly + rv_lat);
         bus.ext_stall_i = (cyc >= ext_from) && (cyc < ext_from + ext_len);
         @(negedge clk);
         if (bus.dm_req_o && bus.dm_ready_i) begin
            acc++;
            strb = bus.dm_wstrb_o;
            wd   = bus.dm_wdata_o;
         end
         if (bus.stall_o) stl++;
         mis |= bus.misalign_o;
         err |= bus.bus_err_o;
         if (!bus.stall_o && !bus.ext_stall_i) begin
            fin = 1'b1;
            res = bus.m_result_o;
         end
         @(posedge clk);
         #1;
      end

      e = sb.pop_front();
      check({e.tag, "/finished"}, 32'(fin), 32'd1);
      check({e.tag, "/result"},   res, e.result);
      check({e.tag, "/misalign"}, 32'(mis), 32'(e.mis));
      check({e.tag, "/bus_err"},  32'(err), 32'(e.err));
      check({e.tag, "/accepts"},  32'(acc), 32'(e.n_acc));
      check({e.tag, "/stall_cyc"}, 32'(stl), 32'(e.n_stall));
      check({e.tag, "/wstrb"},    32'(strb), 32'(e.wstrb));
      check({e.tag, "/wdata"},    wd, e.wdata);
      idle_inputs();
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst/req",      32'(bus.dm_req_o),   32'd0);
      check("rst/we",       32'(bus.dm_we_o),    32'd0);
      check("rst/wstrb",    32'(bus.dm_wstrb_o), 32'd0);
      check("rst/stall",    32'(bus.stall_o),    32'd0);
      check("rst/misalign", 32'(bus.misalign_o), 32'd0);
      check("rst/bus_err",  32'(bus.bus_err_o),  32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      //     tag        op        f3      addr          wdata         rdata        rdy rv ex el  result        mis  err acc stl strb     wdata
      run_op("sw_zw",   OP_STORE, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,       0, 0, 99, 0, 32'h0000_0100, 0, 0, 1, 0, 4'b1111, 32'hDEAD_BEEF);
      run_op("lb_sext", OP_LOAD,  3'b000, 32'h0000_0203, 32'h0,        32'h8012_3456, 0, 3, 99, 0, 32'hFFFF_FF80, 0, 0, 1, 3, 4'b0000, 32'h0);
      run_op("lhu",     OP_LOAD,  3'b101, 32'h0000_0002, 32'h0,        32'hABCD_0000, 0, 1, 99, 0, 32'h0000_ABCD, 0, 0, 1, 1, 4'b0000, 32'h0);
      run_op("sh_hi",   OP_STORE, 3'b001, 32'h0000_0002, 32'h0000_1234, 32'h0,       0, 0, 99, 0, 32'h0000_0002, 0, 0, 1, 0, 4'b1100, 32'h1234_1234);
      run_op("sb_wait", OP_STORE, 3'b000, 32'h0000_0001, 32'h0000_00AB, 32'h0,       2, 0, 99, 0, 32'h0000_0001, 0, 0, 1, 2, 4'b0010, 32'hABAB_ABAB);
      run_op("lh_wait", OP_LOAD,  3'b001, 32'h0000_0000, 32'h0,        32'h1234_8001, 1, 2, 99, 0, 32'hFFFF_8001, 0, 0, 1, 3, 4'b0000, 32'h0);
      run_op("lbu",     OP_LOAD,  3'b100, 32'h0000_0011, 32'h0,        32'h0000_F200, 0, 1, 99, 0, 32'h0000_00F2, 0, 0, 1, 1, 4'b0000, 32'h0);
      run_op("lw_mis",  OP_LOAD,  3'b010, 32'h0000_0101, 32'h0,        32'h0,        0, 1, 99, 0, 32'h0,        1, 0, 0, 0, 4'b0000, 32'h0);
      run_op("sh_mis",  OP_STORE, 3'b001, 32'h0000_0003, 32'h0000_5555, 32'h0,       0, 0, 99, 0, 32'h0,        1, 0, 0, 0, 4'b0000, 32'h0);
      run_op("alu",     OP_ALU,   3'b000, 32'h1234_5678, 32'h0,        32'h0,        0, 0, 99, 0, 32'h1234_5678, 0, 0, 0, 0, 4'b0000, 32'h0);
      run_op("lw_hold", OP_LOAD,  3'b010, 32'h0000_0010, 32'h0,        32'hCAFE_F00D, 0, 1, 1, 2, 32'hCAFE_F00D, 0, 0, 1, 1, 4'b0000, 32'h0);
      run_op("sw_hold", OP_STORE, 3'b010, 32'h0000_0040, 32'h0BAD_F00D, 32'h0,       0, 0, 0, 2, 32'h0000_0040, 0, 0, 1, 0, 4'b1111, 32'h0BAD_F00D);
      run_op("sw_tmo",  OP_STORE, 3'b010, 32'h0000_0080, 32'h1111_2222, 32'h0,      -1, 0, 99, 0, 32'h0,        0, 1, 0, 3, 4'b0000, 32'h0);
      run_op("lw_tmo",  OP_LOAD,  3'b010, 32'h0000_0084, 32'h0,        32'h0,        0, 0, 99, 0, 32'h0,        0, 1, 1, 3, 4'b0000, 32'h0);
      run_op("lw_b2b",  OP_LOAD,  3'b010, 32'h0000_0088, 32'h0,        32'h7654_3210, 0, 1, 99, 0, 32'h7654_3210, 0, 0, 1, 1, 4'b0000, 32'h0);

      // Reset while a load waits for its response, then a stale rvalid arrives.
      bus.m_op_i     = OP_LOAD;
      bus.m_f3_i     = 3'b010;
      bus.m_addr_i   = 32'h0000_0200;
      bus.dm_ready_i = 1'b1;
      @(negedge clk);
      check("rst_resp/issue_req", 32'(bus.dm_req_o), 32'd1);
      @(posedge clk);
      #1;
      bus.dm_ready_i = 1'b0;
      @(negedge clk);
      check("rst_resp/resp_stall", 32'(bus.stall_o), 32'd1);
      check("rst_resp/resp_req",   32'(bus.dm_req_o), 32'd0);
      #1;
      rst = 1'b1;
      #1;
      check("rst_resp/req_in_rst",   32'(bus.dm_req_o), 32'd0);
      check("rst_resp/stall_in_rst", 32'(bus.stall_o),  32'd0);
      idle_inputs();
      bus.m_addr_i = 32'h0000_0055;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      bus.dm_rvalid_i = 1'b1;
      bus.dm_rdata_i  = 32'hFFFF_FFFF;
      @(negedge clk);
      check("rst_resp/stale_result", bus.m_result_o, 32'h0000_0055);
      check("rst_resp/stale_stall",  32'(bus.stall_o), 32'd0);
      @(posedge clk);
      #1;
      idle_inputs();
      run_op("lw_after_rst", OP_LOAD, 3'b010, 32'h0000_0204, 32'h0, 32'h0F0F_0F0F, 0, 2, 99, 0,
             32'h0F0F_0F0F, 0, 0, 1, 2, 4'b0000, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
